// File: rtl/bus_ctrl_fsm_if.sv
// bus_ctrl_fsm_if: start/instr handshake and datapath control bundle for bus_ctrl_fsm
// master: drives start/instr, observes controls; slave: the sequencer side
interface bus_ctrl_fsm_if;
  logic       start;
  logic [8:0] instr;
  logic [3:0] mux_sel;
  logic [7:0] r_in;
  logic       a_in;
  logic       g_in;
  logic       g_sel_din;
  logic       alu_sub;
  logic       busy;
  logic       done;
  modport master (output start, instr,
                  input  mux_sel, r_in, a_in, g_in, g_sel_din, alu_sub, busy, done);
  modport slave  (input  start, instr,
                  output mux_sel, r_in, a_in, g_in, g_sel_din, alu_sub, busy, done);
endinterface

// File: rtl/bus_ctrl_fsm.sv
// bus_ctrl_fsm: instruction sequencer driving bus mux select and register load enables
// clk/rst: rising-edge clock, async active-high reset; bus: start/instr in, mux_sel,
// r_in, a_in, g_in, g_sel_din, alu_sub, busy, done out
module bus_ctrl_fsm #(
  parameter logic [3:0] IDLE_SEL = 4'hF
) (
  input  logic             clk,
  input  logic             rst,
  bus_ctrl_fsm_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;
  state_t     state, nxt;
  logic [8:0] ir;
  logic [2:0] op, rx, ry;
  logic [7:0] rx_hot;
  assign op     = ir[8:6];
  assign rx     = ir[5:3];
  assign ry     = ir[2:0];
  assign rx_hot = 8'b1 << rx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ir    <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && bus.start) ir <= bus.instr;
    end
  end
  always_comb begin
    nxt           = IDLE;
    bus.mux_sel   = IDLE_SEL;
    bus.r_in      = '0;
    bus.a_in      = 1'b0;
    bus.g_in      = 1'b0;
    bus.g_sel_din = 1'b0;
    bus.alu_sub   = 1'b0;
    bus.done      = 1'b0;
    bus.busy      = state != IDLE;
    case (state)
      IDLE: nxt = bus.start ? T1 : IDLE;
      T1: begin
        if (op[2]) begin
          bus.done = 1'b1;
        end else if (op == 3'b000) begin
          bus.mux_sel = {1'b0, ry};
          bus.r_in    = rx_hot;
          bus.done    = 1'b1;
        end else if (op == 3'b001) begin
          bus.g_in      = 1'b1;
          bus.g_sel_din = 1'b1;
          nxt           = T2;
        end else begin
          bus.mux_sel = {1'b0, rx};
          bus.a_in    = 1'b1;
          nxt         = T2;
        end
      end
      T2: begin
        if (op == 3'b001) begin
          bus.mux_sel = 4'd8;
          bus.r_in    = rx_hot;
          bus.done    = 1'b1;
        end else if (op[2:1] == 2'b01) begin
          bus.mux_sel = {1'b0, ry};
          bus.g_in    = 1'b1;
          bus.alu_sub = op[0];
          nxt         = T3;
        end
      end
      T3: begin
        bus.mux_sel = 4'd8;
        bus.r_in    = rx_hot;
        bus.done    = 1'b1;
      end
      default: nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_bus_ctrl_fsm.sv
// tb_bus_ctrl_fsm: table vectors, corner sequences and randomized model check of bus_ctrl_fsm
module tb_bus_ctrl_fsm;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  bus_ctrl_fsm_if bus ();
  bus_ctrl_fsm dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic [3:0] mux_sel;
    logic [7:0] r_in;
    logic a_in, g_in, g_sel_din, alu_sub, busy, done;
  } obs_t;
  typedef struct {
    logic [8:0]     instr;
    int             n;
    obs_t [2:0]     e;
  } vec_t;
  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int last_done = -10;
  obs_t q[$];
  vec_t tbl[5];
  function automatic obs_t mk(logic [3:0] m, logic [7:0] r, logic a, logic g, logic gs,
                              logic sub, logic b, logic d);
    obs_t o;
    o.mux_sel = m; o.r_in = r; o.a_in = a; o.g_in = g;
    o.g_sel_din = gs; o.alu_sub = sub; o.busy = b; o.done = d;
    return o;
  endfunction
  function automatic obs_t st(logic [3:0] m, logic [7:0] r, logic a, logic g, logic gs,
                              logic sub, logic d);
    return mk(m, r, a, g, gs, sub, 1'b1, d);
  endfunction
  function automatic obs_t idle_o();
    return mk(4'hF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic obs_t act();
    return mk(bus.mux_sel, bus.r_in, bus.a_in, bus.g_in, bus.g_sel_din, bus.alu_sub,
              bus.busy, bus.done);
  endfunction
  task automatic chk(string name, obs_t e);
    obs_t a;
    a = act();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s @cyc %0d got mux=%h r_in=%h a=%b g=%b gsel=%b sub=%b busy=%b done=%b, expected mux=%h r_in=%h a=%b g=%b gsel=%b sub=%b busy=%b done=%b",
               name, cycle, a.mux_sel, a.r_in, a.a_in, a.g_in, a.g_sel_din, a.alu_sub, a.busy, a.done,
               e.mux_sel, e.r_in, e.a_in, e.g_in, e.g_sel_din, e.alu_sub, e.busy, e.done);
    end
  endtask
  // Reference: each instruction expands into its per-cycle list of bus controls.
  function automatic void expand(logic [8:0] i);
    logic [2:0] op, rx, ry;
    logic [7:0] h;
    op = i[8:6]; rx = i[5:3]; ry = i[2:0];
    h = 8'h00;
    h[rx] = 1'b1;
    if (op >= 3'd4) q.push_back(st(4'hF, 8'h00, 0, 0, 0, 0, 1));
    else if (op == 3'd0) q.push_back(st({1'b0, ry}, h, 0, 0, 0, 0, 1));
    else if (op == 3'd1) begin
      q.push_back(st(4'hF, 8'h00, 0, 1, 1, 0, 0));
      q.push_back(st(4'd8, h, 0, 0, 0, 0, 1));
    end else begin
      q.push_back(st({1'b0, rx}, 8'h00, 1, 0, 0, 0, 0));
      q.push_back(st({1'b0, ry}, 8'h00, 0, 1, 0, op == 3'd3, 0));
      q.push_back(st(4'd8, h, 0, 0, 0, 0, 1));
    end
  endfunction
  task automatic cyc(string name, logic s, logic [8:0] i);
    bit idle_now;
    @(negedge clk);
    cycle++;
    idle_now = q.size() == 0;
    chk(name, idle_now ? idle_o() : q.pop_front());
    checks++;
    if ($countones(bus.r_in) > 1) begin
      errors++;
      $display("FAIL %s r_in onehot got %h required at most one bit", name, bus.r_in);
    end
    if (bus.done) begin
      checks++;
      if (cycle - last_done < 2) begin
        errors++;
        $display("FAIL %s done spacing got %0d required >=2", name, cycle - last_done);
      end
      last_done = cycle;
    end
    bus.start = s;
    bus.instr = i;
    if (idle_now && s) expand(i);
  endtask
  initial begin
    tbl[0] = '{9'b000_101_010, 1, {obs_t'(0), obs_t'(0), st(4'd2, 8'h20, 0, 0, 0, 0, 1)}};
    tbl[1] = '{9'b001_001_000, 2, {obs_t'(0), st(4'd8, 8'h02, 0, 0, 0, 0, 1),
                                    st(4'hF, 8'h00, 0, 1, 1, 0, 0)}};
    tbl[2] = '{9'b011_011_111, 3, {st(4'd8, 8'h08, 0, 0, 0, 0, 1), st(4'd7, 8'h00, 0, 1, 0, 1, 0),
                                    st(4'd3, 8'h00, 1, 0, 0, 0, 0)}};
    tbl[3] = '{9'b010_011_111, 3, {st(4'd8, 8'h08, 0, 0, 0, 0, 1), st(4'd7, 8'h00, 0, 1, 0, 0, 0),
                                    st(4'd3, 8'h00, 1, 0, 0, 0, 0)}};
    tbl[4] = '{9'b100_000_000, 1, {obs_t'(0), obs_t'(0), st(4'hF, 8'h00, 0, 0, 0, 0, 1)}};
    rst = 1'b1;
    bus.start = 1'b0;
    bus.instr = '0;
    #2;
    chk("reset", idle_o());
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) cyc("idle", 1'b0, 9'h0);
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.instr = tbl[v].instr;
      for (int c = 0; c < tbl[v].n; c++) begin
        @(negedge clk);
        chk($sformatf("vec%0d step%0d", v, c), tbl[v].e[c]);
        bus.start = 1'b0;
        bus.instr = $urandom;
      end
      @(negedge clk);
      chk($sformatf("vec%0d retire", v), idle_o());
    end
    cyc("hold accept add", 1'b1, 9'b010_001_010);
    for (int k = 0; k < 4; k++) cyc("hold add/mv", 1'b1, 9'b000_100_001);
    for (int k = 0; k < 3; k++) cyc("hold drain", 1'b0, 9'h0);
    cyc("ar accept", 1'b1, 9'b010_010_011);
    cyc("ar t1", 1'b0, 9'h0);
    @(posedge clk);
    #1;
    chk("ar t2", st(4'd3, 8'h00, 0, 1, 0, 0, 0));
    #1;
    rst = 1'b1;
    #1;
    chk("ar async idle", idle_o());
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    cyc("post rst nop", 1'b1, 9'b100_000_000);
    cyc("nop t1", 1'b0, 9'h0);
    cyc("nop retire", 1'b0, 9'h0);
    for (int k = 0; k < 400; k++)
      cyc("rand", $urandom_range(0, 2) != 0, 9'($urandom));
    for (int k = 0; k < 4; k++) cyc("rand drain", 1'b0, 9'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_ctrl_fsm.md
Name: bus_ctrl_fsm

Overview:
- Control sequencer directly upstream of the 9-input 16-bit bus mux in the simple-processor datapath.
- Accepts one 9-bit instruction per start handshake and drives the mux select and the register, accumulator and result-register load enables, cycle by cycle, until the instruction retires.
- Mux select encoding it drives: 0–7 = R0–R7, 8 = G (result register), any other code = bus reads 0.

Parameters:
IDLE_SEL, 4'hF, mux_sel value driven when no bus transfer is active; must be outside 0–8 so the bus reads 0.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request to execute instr; sampled only in IDLE
instr  in  9  instruction {op[8:6], rx[5:3], ry[2:0]}
mux_sel  out  4  bus mux select
r_in  out  8  one-hot load enable for R0–R7
a_in  out  1  load enable for ALU operand register A (from bus)
g_in  out  1  load enable for G
g_sel_din  out  1  G input select: 0 = ALU result, 1 = external DIN
alu_sub  out  1  ALU operation: 0 = A+bus, 1 = A−bus
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse in the final cycle of an instruction

Behaviour:
- Reset is asynchronous, active-high:
  - State goes to IDLE and IR to 9'd0.
  - All outputs go to idle values immediately: mux_sel = IDLE_SEL, r_in = 0, a_in = g_in = g_sel_din = alu_sub = 0, busy = 0, done = 0.
- States: IDLE, T1, T2, T3. All outputs are decoded combinationally from state and IR. Registered loads take effect at the next rising edge.
- IDLE:
  - All enables 0.
  - If start = 1: IR <= instr, next state T1.
  - start while busy = 1 is ignored and not queued. The earliest next accept is the cycle after done.
- Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 1xx nop.
- mv Rx,Ry (1 cycle):
  - T1: mux_sel = ry, r_in[rx] = 1, done = 1, next IDLE.
- mvi Rx,DIN (2 cycles):
  - T1: g_in = 1, g_sel_din = 1, next T2.
  - T2: mux_sel = 8, r_in[rx] = 1, done = 1, next IDLE.
- add/sub Rx,Ry (3 cycles):
  - T1: mux_sel = rx, a_in = 1, next T2.
  - T2: mux_sel = ry, g_in = 1, g_sel_din = 0, alu_sub = (op == 011), next T3.
  - T3: mux_sel = 8, r_in[rx] = 1, done = 1, next IDLE.
- nop (1 cycle):
  - T1: no enables, mux_sel = IDLE_SEL, done = 1, next IDLE.
- In any cycle where no bus transfer is required, mux_sel = IDLE_SEL.
- r_in is always one-hot or zero, never multi-hot.
- rx == ry is legal and needs no special handling (mv R3,R3 rewrites R3; add R2,R2 doubles R2).
- Latency from the start-accept edge to done high: mv/nop 1 cycle, mvi 2, add/sub 3.
- Reset asserted mid-instruction aborts it. No partial enables persist after rst rises.
- instr changes while busy have no effect; IR is held.

Test Plan:
- Reset, then idle: rst pulse, start = 0 for 5 cycles → mux_sel = 4'hF, r_in = 0, busy = 0, done = 0 throughout.
- mv R5,R2 (instr = 9'b000_101_010), start for 1 cycle → next cycle mux_sel = 2, r_in = 8'h20, done = 1; following cycle IDLE, busy = 0.
- mvi R1 (9'b001_001_000) → T1: g_in = 1, g_sel_din = 1, mux_sel = F; T2: mux_sel = 8, r_in = 8'h02, done = 1.
- sub R3,R7 (9'b011_011_111):
  - T1: mux_sel = 3, a_in = 1.
  - T2: mux_sel = 7, g_in = 1, alu_sub = 1.
  - T3: mux_sel = 8, r_in = 8'h08, done = 1.
  - Repeat as add → alu_sub = 0 in T2.
- Start held high continuously over add then mv (instr changed mid-add) → add completes unchanged with IR held; mv accepted only in the IDLE cycle after done; never two dones closer than 2 cycles apart.
- rst asserted asynchronously during T2 of add → outputs go to idle values before the next clock edge, state IDLE; next start with nop (9'b100_000_000) gives done in T1 with no enables.
